// File: rtl/usb_rx_decoder.sv
// rtl/usb_rx_decoder.sv - USB full-speed receive decoder: SYNC, NRZI, destuffing, byte assembly, EOP
// Optional build macro USB_RX_EDGE_RESYNC_EN re-centres the bit sampler on every J<->K edge inside a packet.
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_STROBE = PW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {LV_SE0 = 2'd0, LV_J = 2'd1, LV_K = 2'd2} level_e;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_WAIT_IDLE} state_e;

  logic          dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q;
  level_e        cur_lvl, prev_lvl_q;
  level_e        last_lvl_q, last_lvl_d;
  logic [PW-1:0] phase_q, phase_d;
  state_e        state_q, state_d;
  logic [2:0]    sync_cnt_q, sync_cnt_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          se0_twice_q, se0_twice_d;
  logic [2:0]    j_cnt_q, j_cnt_d;
  logic          wait_se0_q, wait_se0_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          active_q, active_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;

  logic strobe, is_se0, nrzi_bit, jk_edge;

  always_comb begin
    case ({dp_sync_q, dm_sync_q})
      2'b10:   cur_lvl = LV_J;
      2'b01:   cur_lvl = LV_K;
      default: cur_lvl = LV_SE0;
    endcase
  end

  assign strobe   = (phase_q == PHASE_STROBE);
  assign is_se0   = (cur_lvl == LV_SE0);
  assign nrzi_bit = (cur_lvl == last_lvl_q);
  assign jk_edge  = (prev_lvl_q == LV_J) && (cur_lvl == LV_K);

`ifdef USB_RX_EDGE_RESYNC_EN
  logic any_edge;
  assign any_edge = ((prev_lvl_q == LV_J) && (cur_lvl == LV_K)) ||
                    ((prev_lvl_q == LV_K) && (cur_lvl == LV_J));
`endif

  always_comb begin
    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
    if ((state_q == S_IDLE) && jk_edge) begin
      phase_d = '0;
    end
`ifdef USB_RX_EDGE_RESYNC_EN
    if (((state_q == S_SYNC) || (state_q == S_DATA) || (state_q == S_EOP)) && any_edge) begin
      phase_d = '0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    last_lvl_d  = last_lvl_q;
    sync_cnt_d  = sync_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    se0_twice_d = se0_twice_q;
    j_cnt_d     = j_cnt_q;
    wait_se0_d  = wait_se0_q;
    data_d      = data_q;
    active_d    = active_q;
    valid_d     = 1'b0;
    eop_d       = 1'b0;
    err_d       = 1'b0;

    if (strobe && !is_se0) begin
      last_lvl_d = cur_lvl;
    end

    case (state_q)
      S_IDLE: begin
        if (jk_edge) begin
          state_d    = S_SYNC;
          sync_cnt_d = 3'd0;
        end
      end

      S_SYNC: begin
        if (strobe) begin
          if (!is_se0 && !nrzi_bit && (sync_cnt_q != 3'd7)) begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end else if (!is_se0 && nrzi_bit && (sync_cnt_q == 3'd7)) begin
            state_d    = S_DATA;
            active_d   = 1'b1;
            ones_cnt_d = 3'd1;
            bit_cnt_d  = 3'd0;
          end else begin
            // Malformed SYNC is treated as line noise: no error pulse.
            state_d    = S_WAIT_IDLE;
            j_cnt_d    = 3'd0;
            wait_se0_d = is_se0;
          end
        end
      end

      S_DATA: begin
        if (strobe) begin
          if (is_se0) begin
            state_d     = S_EOP;
            se0_twice_d = 1'b0;
          end else if (ones_cnt_q == 3'd6) begin
            if (nrzi_bit) begin
              err_d      = 1'b1;
              active_d   = 1'b0;
              state_d    = S_WAIT_IDLE;
              j_cnt_d    = 3'd0;
              wait_se0_d = 1'b0;
            end else begin
              ones_cnt_d = 3'd0;
            end
          end else begin
            shreg_d    = {nrzi_bit, shreg_q[7:1]};
            ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_d  = {nrzi_bit, shreg_q[7:1]};
              valid_d = 1'b1;
            end
          end
        end
      end

      S_EOP: begin
        if (strobe) begin
          if (is_se0) begin
            se0_twice_d = 1'b1;
          end else if ((cur_lvl == LV_J) && se0_twice_q) begin
            eop_d     = 1'b1;
            err_d     = (bit_cnt_q != 3'd0);
            active_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = S_IDLE;
          end else begin
            err_d      = 1'b1;
            active_d   = 1'b0;
            state_d    = S_WAIT_IDLE;
            j_cnt_d    = 3'd0;
            wait_se0_d = 1'b0;
          end
        end
      end

      S_WAIT_IDLE: begin
        active_d = 1'b0;
        if (strobe) begin
          if (cur_lvl == LV_J) begin
            if (wait_se0_q || (j_cnt_q == 3'd7)) begin
              state_d    = S_IDLE;
              j_cnt_d    = 3'd0;
              wait_se0_d = 1'b0;
            end else begin
              j_cnt_d = j_cnt_q + 3'd1;
            end
          end else if (cur_lvl == LV_K) begin
            j_cnt_d    = 3'd0;
            wait_se0_d = 1'b0;
          end else begin
            j_cnt_d    = 3'd0;
            wait_se0_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_meta_q   <= 1'b1;
      dp_sync_q   <= 1'b1;
      dm_meta_q   <= 1'b0;
      dm_sync_q   <= 1'b0;
      prev_lvl_q  <= LV_J;
      last_lvl_q  <= LV_J;
      phase_q     <= '0;
      state_q     <= S_IDLE;
      sync_cnt_q  <= 3'd0;
      ones_cnt_q  <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      se0_twice_q <= 1'b0;
      j_cnt_q     <= 3'd0;
      wait_se0_q  <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dp_meta_q   <= dplus_in;
      dp_sync_q   <= dp_meta_q;
      dm_meta_q   <= dminus_in;
      dm_sync_q   <= dm_meta_q;
      prev_lvl_q  <= cur_lvl;
      last_lvl_q  <= last_lvl_d;
      phase_q     <= phase_d;
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      se0_twice_q <= se0_twice_d;
      j_cnt_q     <= j_cnt_d;
      wait_se0_q  <= wait_se0_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      eop_q       <= eop_d;
      err_q       <= err_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_active     = active_q;
  assign rx_eop        = eop_q;
  assign rx_error      = err_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb/tb_usb_rx_decoder.sv - scoreboard bench for usb_rx_decoder
// Stimulus drives NRZI line levels; a forked monitor pops expected pulses as the DUT emits them.
module tb_usb_rx_decoder;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       dplus_in;
  logic       dminus_in;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;

  always #5 clk = ~clk;

  usb_rx_decoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .dplus_in     (dplus_in),
    .dminus_in    (dminus_in),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_active    (rx_active),
    .rx_eop       (rx_eop),
    .rx_error     (rx_error)
  );

  localparam logic [2:0] EV_BYTE = 3'b100;
  localparam logic [2:0] EV_EOP  = 3'b010;
  localparam logic [2:0] EV_ERR  = 3'b001;
  localparam logic [2:0] EV_BOTH = 3'b011;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_act;
  logic [10:0] mon_exp;
  logic [2:0]  mon_pulse;
  logic [2:0]  mon_prev = 3'b000;

  int   bit_len = CPB;
  bit   alt_mode = 1'b0;
  logic cur_k = 1'b0;
  int   ones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [7:0] d);
    exp_q.push_back({kind, d});
  endtask

  task automatic drive(input logic dp, input logic dm);
    int n;
    dplus_in  = dp;
    dminus_in = dm;
    n = bit_len;
    if (alt_mode) bit_len = (bit_len == 4) ? 5 : 4;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_nrzi(input logic b);
    if (!b) cur_k = ~cur_k;
    drive(~cur_k, cur_k);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_nrzi(1'b0);
    send_nrzi(1'b1);
    ones = 1;
  endtask

  task automatic send_data_bit(input logic b, input bit stuff);
    send_nrzi(b);
    ones = b ? ones + 1 : 0;
    if (stuff && ones == 6) begin
      send_nrzi(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i], 1'b1);
  endtask

  task automatic send_se0(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic send_idle(input int n);
    cur_k = 1'b0;
    repeat (n) drive(1'b1, 1'b0);
  endtask

  task automatic send_eop();
    send_se0(2);
    send_idle(10);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          mon_pulse = {rx_data_valid, rx_eop, rx_error};
          if (!rst && (mon_pulse != 3'b000)) begin
            mon_act = {mon_pulse, rx_data_valid ? rx_data : 8'h00};
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_output act=%h exp=none", mon_act);
            end else begin
              mon_exp = exp_q.pop_front();
              if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL scoreboard act=%h exp=%h", mon_act, mon_exp);
              end
            end
            if (rx_data_valid) begin
              checks++;
              if (rx_active !== 1'b1) begin
                errors++;
                $display("FAIL active_with_data act=%b exp=1", rx_active);
              end
            end
          end
          if (!rst && ((mon_pulse & mon_prev) != 3'b000)) begin
            checks++;
            errors++;
            $display("FAIL pulse_width act=%b prev=%b exp=single_cycle", mon_pulse, mon_prev);
          end
          mon_prev = mon_pulse;
        end
      end
    join_none

    // Power-on reset
    rst = 1'b1;
    dplus_in = 1'b1;
    dminus_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx_data, rx_data_valid, rx_active, rx_eop, rx_error}, 0);
    rst = 1'b0;
    send_idle(10);

    // T2: SYNC + 0xA5 + EOP
    push(EV_BYTE, 8'hA5);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'hA5);
    send_eop();
    wait_drain("t2_drain");
    chk("t2_active_after", rx_active, 0);
    chk("t2_data_hold", rx_data, 8'hA5);

    // T1: reset mid-packet
    send_sync();
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    chk("t1_active_mid", rx_active, 1);
    rst = 1'b1;
    dplus_in = 1'b1;
    dminus_in = 1'b0;
    cur_k = 1'b0;
    @(negedge clk);
    chk("t1_reset_outputs", {rx_data, rx_data_valid, rx_active, rx_eop, rx_error}, 0);
    @(negedge clk);
    rst = 1'b0;
    send_idle(10);
    push(EV_BYTE, 8'hC3);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'hC3);
    send_eop();
    wait_drain("t1_drain");

    // T3: stuffed bytes 0xFF, 0x7E
    push(EV_BYTE, 8'hFF);
    push(EV_BYTE, 8'h7E);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h7E);
    send_eop();
    wait_drain("t3_drain");

    // T4: seven ones without a stuff bit
    push(EV_ERR, 8'h00);
    send_sync();
    for (int i = 0; i < 7; i++) send_data_bit(1'b1, 1'b0);
    send_eop();
    wait_drain("t4_drain");
    chk("t4_active_after", rx_active, 0);

    // T5: EOP after 4 data bits
    push(EV_BOTH, 8'h00);
    send_sync();
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    send_data_bit(1'b1, 1'b1);
    send_data_bit(1'b0, 1'b1);
    send_eop();
    wait_drain("t5_drain");

    // Noisy SYNC (1 after three zeros), then a clean packet
    send_nrzi(1'b0);
    send_nrzi(1'b0);
    send_nrzi(1'b0);
    send_nrzi(1'b1);
    send_idle(12);
    chk("noise_active", rx_active, 0);
    push(EV_BYTE, 8'h5A);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'h5A);
    send_eop();
    wait_drain("noise_drain");

    // Single-bit SE0 is a malformed EOP
    push(EV_BYTE, 8'h3C);
    push(EV_ERR, 8'h00);
    send_sync();
    send_byte(8'h3C);
    send_se0(1);
    send_idle(12);
    wait_drain("short_se0_drain");

    // SE0 held for three bits is still a valid EOP
    push(EV_BYTE, 8'h01);
    push(EV_EOP, 8'h00);
    send_sync();
    send_byte(8'h01);
    send_se0(3);
    send_idle(10);
    wait_drain("long_se0_drain");

`ifdef USB_RX_EDGE_RESYNC_EN
    // T6: bit period alternating 4/5 clocks
    alt_mode = 1'b1;
    bit_len = 4;
    for (int i = 0; i < 4; i++) push(EV_BYTE, 8'h00);
    push(EV_EOP, 8'h00);
    send_sync();
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    send_eop();
    alt_mode = 1'b0;
    bit_len = CPB;
    wait_drain("t6_drain");
`endif

    send_idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
